// File: rtl/mips_multicycle_ctrl_pkg.sv
// rtl/mips_multicycle_ctrl_pkg.sv - shared opcodes, control encodings and FSM states
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_AND} alu_op_e;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP, PC_A} pc_src_e;
  typedef enum logic [1:0] {WD_ALUOUT, WD_MDR, WD_PC, WD_RSVD} mem_to_reg_e;
  typedef enum logic [1:0] {RD_RT, RD_RD, RD_RA, RD_RSVD} reg_dst_e;
  typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} alu_src_b_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_ADDI_EXEC, S_ANDI_EXEC, S_IMM_WB,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BEQ, S_JAL, S_JR
  } state_e;

  // States that own the memory port and therefore wait on mem_ready.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
interface mips_multicycle_ctrl_if #(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
);
  logic [OP_W-1:0]    op_code;
  logic [FUNCT_W-1:0] funct;
  logic               zero;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         MemtoReg;
  logic [1:0]         RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSource;
  logic               instr_done;
  logic               illegal_op;
  logic               mem_timeout;

  modport master (
    input  op_code, funct, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal_op, mem_timeout
  );

  modport slave (
    output op_code, funct, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// rtl/mips_multicycle_ctrl_mem_wait_timer.sv - saturating mem_ready wait counter with timeout
module mem_wait_timer #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic timeout
);
  logic [CNT_W-1:0] count;

  assign timeout = active && !ready && (count == CNT_W'(WAIT_MAX));

  // Held at zero outside wait states, so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset || !active || ready || timeout) begin
      count <= '0;
    end else if (count != CNT_W'(WAIT_MAX)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with shared memory port
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input logic                    clk,
  input logic                    reset,
  mips_multicycle_ctrl_if.master bus
);
  state_e state, state_nxt;
  logic   timeout;

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (is_wait_state(state)),
    .ready   (bus.mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = WD_ALUOUT;
    bus.RegDst      = RD_RT;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_B;
    bus.ALUOp       = ALU_ADD;
    bus.PCSource    = PC_ALU;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.mem_timeout = 1'b0;
    // An abort drops every strobe, including the memory request itself.
    if (!reset && timeout) begin
      bus.mem_timeout = 1'b1;
      state_nxt       = S_FETCH;
    end else if (!reset) begin
      unique case (state)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = SRCB_FOUR;
          if (bus.mem_ready) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
            state_nxt   = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.ALUSrcB = SRCB_IMM_SH2;
          case (bus.op_code)
            OP_RTYPE:     state_nxt = (bus.funct == FUNCT_JR) ? S_JR : S_R_EXEC;
            OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
            OP_ADDI:      state_nxt = S_ADDI_EXEC;
            OP_ANDI:      state_nxt = S_ANDI_EXEC;
            OP_BEQ:       state_nxt = S_BEQ;
            OP_JAL:       state_nxt = S_JAL;
            default: begin
              bus.illegal_op = 1'b1;
              state_nxt      = S_FETCH;
            end
          endcase
        end
        S_R_EXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = ALU_FUNCT;
          state_nxt   = S_R_WB;
        end
        S_R_WB: begin
          bus.RegDst     = RD_RD;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        S_ADDI_EXEC, S_ANDI_EXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
          bus.ALUOp   = (state == S_ANDI_EXEC) ? ALU_AND : ALU_ADD;
          state_nxt   = S_IMM_WB;
        end
        S_IMM_WB: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        S_MEM_ADDR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
          state_nxt   = (bus.op_code == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
          if (bus.mem_ready) state_nxt = S_MEM_WB;
        end
        S_MEM_WB: begin
          bus.MemtoReg   = WD_MDR;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        S_MEM_WR: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
          if (bus.mem_ready) begin
            bus.instr_done = 1'b1;
            state_nxt      = S_FETCH;
          end
        end
        S_BEQ: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = ALU_SUB;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = PC_ALUOUT;
          bus.instr_done  = 1'b1;
          state_nxt       = S_FETCH;
        end
        S_JAL: begin
          bus.RegDst     = RD_RA;
          bus.MemtoReg   = WD_PC;
          bus.RegWrite   = 1'b1;
          bus.PCWrite    = 1'b1;
          bus.PCSource   = PC_JUMP;
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        S_JR: begin
          bus.PCWrite    = 1'b1;
          bus.PCSource   = PC_A;
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed table plus randomized model check of mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  localparam int WAIT_MAX = 4;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] MemtoReg;
    logic [1:0] RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
  } outs_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic       z;
    outs_t      exp;
  } vec_t;

  typedef enum {C_R, C_ADDI, C_ANDI, C_LW, C_SW, C_BEQ, C_JAL, C_JR, C_ILL} cls_e;

  localparam outs_t O_ZERO = '0;
  localparam outs_t O_FW  = '{MemRead: 1'b1, ALUSrcB: 2'b01, default: '0};
  localparam outs_t O_FR  = '{MemRead: 1'b1, ALUSrcB: 2'b01, IRWrite: 1'b1, PCWrite: 1'b1, default: '0};
  localparam outs_t O_DEC = '{ALUSrcB: 2'b11, default: '0};
  localparam outs_t O_ILL = '{ALUSrcB: 2'b11, illegal_op: 1'b1, default: '0};
  localparam outs_t O_REX = '{ALUSrcA: 1'b1, ALUOp: 2'b10, default: '0};
  localparam outs_t O_RWB = '{RegDst: 2'b01, RegWrite: 1'b1, instr_done: 1'b1, default: '0};
  localparam outs_t O_IEX = '{ALUSrcA: 1'b1, ALUSrcB: 2'b10, default: '0};
  localparam outs_t O_AEX = '{ALUSrcA: 1'b1, ALUSrcB: 2'b10, ALUOp: 2'b11, default: '0};
  localparam outs_t O_IWB = '{RegWrite: 1'b1, instr_done: 1'b1, default: '0};
  localparam outs_t O_MRD = '{MemRead: 1'b1, IorD: 1'b1, default: '0};
  localparam outs_t O_MWB = '{MemtoReg: 2'b01, RegWrite: 1'b1, instr_done: 1'b1, default: '0};
  localparam outs_t O_MWW = '{MemWrite: 1'b1, IorD: 1'b1, default: '0};
  localparam outs_t O_MWR = '{MemWrite: 1'b1, IorD: 1'b1, instr_done: 1'b1, default: '0};
  localparam outs_t O_BEQ = '{ALUSrcA: 1'b1, ALUOp: 2'b01, PCWriteCond: 1'b1, PCSource: 2'b01,
                              instr_done: 1'b1, default: '0};
  localparam outs_t O_JAL = '{RegDst: 2'b10, MemtoReg: 2'b10, RegWrite: 1'b1, PCWrite: 1'b1,
                              PCSource: 2'b10, instr_done: 1'b1, default: '0};
  localparam outs_t O_JR  = '{PCWrite: 1'b1, PCSource: 2'b11, instr_done: 1'b1, default: '0};
  localparam outs_t O_TMO = '{mem_timeout: 1'b1, default: '0};

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  mips_multicycle_ctrl_if #(.OP_W(6), .FUNCT_W(6)) bus ();

  mips_multicycle_ctrl #(.OP_W(6), .FUNCT_W(6), .WAIT_MAX(WAIT_MAX), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Reference: an instruction is a numbered step sequence; steps 0 and 3 of lw/sw use memory.
  int   m_step = 0;
  int   m_wait = 0;
  cls_e m_cls  = C_ILL;

  function automatic cls_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b001000) ? C_JR : C_R;
      6'b001000: return C_ADDI;
      6'b001100: return C_ANDI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000011: return C_JAL;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int seq_len(input cls_e c);
    case (c)
      C_ILL:                 return 2;
      C_BEQ, C_JAL, C_JR:    return 3;
      C_LW:                  return 5;
      default:               return 4;
    endcase
  endfunction

  function automatic outs_t body(input cls_e c, input int k, input logic rdy);
    outs_t r2 [9] = '{O_REX, O_IEX, O_AEX, O_IEX, O_IEX, O_BEQ, O_JAL, O_JR, O_ZERO};
    if (k == 2) return r2[int'(c)];
    case (c)
      C_R:          return O_RWB;
      C_ADDI, C_ANDI: return O_IWB;
      C_LW:         return (k == 3) ? O_MRD : O_MWB;
      C_SW:         return rdy ? O_MWR : O_MWW;
      default:      return O_ZERO;
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic rdy, input logic [5:0] op,
                            input logic [5:0] fn, output outs_t e);
    logic mem;
    if (rst) begin
      e = O_ZERO; m_step = 0; m_wait = 0;
      return;
    end
    if (m_step == 1) m_cls = classify(op, fn);
    mem = (m_step == 0) || (m_step == 3 && (m_cls == C_LW || m_cls == C_SW));
    if (mem && !rdy && m_wait == WAIT_MAX) begin
      e = O_TMO; m_step = 0; m_wait = 0;
      return;
    end
    if (m_step == 0)      e = rdy ? O_FR : O_FW;
    else if (m_step == 1) e = (m_cls == C_ILL) ? O_ILL : O_DEC;
    else                  e = body(m_cls, m_step, rdy);
    if (mem && !rdy) begin
      m_wait++;
      return;
    end
    m_wait = 0;
    if (m_step == 0)                      m_step = 1;
    else if (m_step + 1 >= seq_len(m_cls)) m_step = 0;
    else                                  m_step++;
  endtask

  task automatic apply(input vec_t v, input string name);
    outs_t got;
    @(negedge clk);
    reset         = v.rst;
    bus.op_code   = v.op;
    bus.funct     = v.fn;
    bus.mem_ready = v.rdy;
    bus.zero      = v.z;
    #1;
    got = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
           bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
           bus.PCSource, bus.instr_done, bus.illegal_op, bus.mem_timeout};
    vectors++;
    if (got !== v.exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: outputs %b, expected %b", name, vectors, got, v.exp);
    end
  endtask

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic z, input outs_t e);
    tbl.push_back('{rst: rst, op: op, fn: fn, rdy: rdy, z: z, exp: e});
  endtask

  initial begin
    logic [5:0] ops [9] = '{6'b000000, 6'b000000, 6'b001000, 6'b001100, 6'b100011,
                            6'b101011, 6'b000100, 6'b000011, 6'b111111};
    logic [5:0] op, fn;
    int         thr;
    vec_t       v;

    reset = 1'b1;
    bus.op_code = '0; bus.funct = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;

    add(1, 6'h00, 6'h20, 1, 0, O_ZERO);
    // add
    add(0, 6'h00, 6'h20, 1, 0, O_FR);  add(0, 6'h00, 6'h20, 1, 0, O_DEC);
    add(0, 6'h00, 6'h20, 1, 0, O_REX); add(0, 6'h00, 6'h20, 1, 0, O_RWB);
    // lw with three stalled MEM_RD cycles
    add(0, 6'h23, 6'h00, 1, 0, O_FR);  add(0, 6'h23, 6'h00, 0, 0, O_DEC);
    add(0, 6'h23, 6'h00, 1, 0, O_IEX); add(0, 6'h23, 6'h00, 0, 0, O_MRD);
    add(0, 6'h23, 6'h00, 0, 0, O_MRD); add(0, 6'h23, 6'h00, 0, 0, O_MRD);
    add(0, 6'h23, 6'h00, 1, 0, O_MRD); add(0, 6'h23, 6'h00, 1, 0, O_MWB);
    // beq taken / not taken
    add(0, 6'h04, 6'h00, 1, 1, O_FR);  add(0, 6'h04, 6'h00, 1, 1, O_DEC);
    add(0, 6'h04, 6'h00, 1, 1, O_BEQ);
    add(0, 6'h04, 6'h00, 1, 0, O_FR);  add(0, 6'h04, 6'h00, 1, 0, O_DEC);
    add(0, 6'h04, 6'h00, 1, 0, O_BEQ);
    // jal then jr
    add(0, 6'h03, 6'h00, 1, 0, O_FR);  add(0, 6'h03, 6'h00, 1, 0, O_DEC);
    add(0, 6'h03, 6'h00, 1, 0, O_JAL);
    add(0, 6'h00, 6'h08, 1, 0, O_FR);  add(0, 6'h00, 6'h08, 1, 0, O_DEC);
    add(0, 6'h00, 6'h08, 1, 0, O_JR);
    // illegal opcode
    add(0, 6'h3f, 6'h00, 1, 0, O_FR);  add(0, 6'h3f, 6'h00, 1, 0, O_ILL);
    // sw interrupted by reset while waiting in MEM_WR
    add(0, 6'h2b, 6'h00, 1, 0, O_FR);  add(0, 6'h2b, 6'h00, 1, 0, O_DEC);
    add(0, 6'h2b, 6'h00, 1, 0, O_IEX); add(0, 6'h2b, 6'h00, 0, 0, O_MWW);
    add(1, 6'h2b, 6'h00, 0, 0, O_ZERO);
    // fetch timeout after WAIT_MAX waits, then retry
    for (int i = 0; i < WAIT_MAX; i++) add(0, 6'h08, 6'h00, 0, 0, O_FW);
    add(0, 6'h08, 6'h00, 0, 0, O_TMO);
    add(0, 6'h08, 6'h00, 0, 0, O_FW);
    // addi and andi
    add(0, 6'h08, 6'h00, 1, 0, O_FR);  add(0, 6'h08, 6'h00, 1, 0, O_DEC);
    add(0, 6'h08, 6'h00, 1, 0, O_IEX); add(0, 6'h08, 6'h00, 1, 0, O_IWB);
    add(0, 6'h0c, 6'h00, 1, 0, O_FR);  add(0, 6'h0c, 6'h00, 1, 0, O_DEC);
    add(0, 6'h0c, 6'h00, 1, 0, O_AEX); add(0, 6'h0c, 6'h00, 1, 0, O_IWB);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "directed");

    op = '0; fn = '0; thr = 10;
    for (int i = 0; i < 4000; i++) begin
      v.rst = (i == 0) || ($urandom_range(0, 299) == 0);
      if (m_step == 0) begin
        op  = ops[$urandom_range(0, 8)];
        if (op == 6'b111111) op = 6'($urandom);
        fn  = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
        thr = (($urandom_range(0, 2) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 10 : 6));
      end
      v.op  = op;
      v.fn  = fn;
      v.rdy = ($urandom_range(0, 9) < thr);
      v.z   = 1'($urandom);
      model_step(v.rst, v.rdy, v.op, v.fn, v.exp);
      apply(v, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
